// File: rtl/tb_console_pkg.sv
// ---------------------------------------------------------------------------
// tb_console_pkg : register map, FSM encodings and STATUS layout shared by
//                  the console device and its FIFO.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tb_console_pkg;

  localparam logic [11:0] TXDATA_OFS   = 12'h200;
  localparam logic [11:0] STATUS_OFS   = 12'h204;
  localparam logic [11:0] CYCLE_LO_OFS = 12'h208;
  localparam logic [11:0] CYCLE_HI_OFS = 12'h20C;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int STAT_COUNT_W   = 5;
  localparam int STAT_FULL_BIT  = 8;
  localparam int STAT_EMPTY_BIT = 9;
  localparam int STAT_DONE_BIT  = 16;

  function automatic logic [31:0] status_word(input logic [STAT_COUNT_W-1:0] count,
                                              input logic full,
                                              input logic empty,
                                              input logic done);
    logic [31:0] s;
    s = 32'h0;
    s[STAT_COUNT_W-1:0] = count;
    s[STAT_FULL_BIT]    = full;
    s[STAT_EMPTY_BIT]   = empty;
    s[STAT_DONE_BIT]    = done;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tb_char_fifo.sv
// ---------------------------------------------------------------------------
// tb_char_fifo : synchronous 8-bit FIFO with extra-MSB pointers for
//                full/empty detection.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    // Head reads as zero when empty so the output is defined out of reset.
    rdata    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tb_console_dev.sv
// ---------------------------------------------------------------------------
// tb_console_dev : memory-mapped console, end-of-test flag and 64-bit cycle
//                  counter on the testbench data bus.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_console_dev
  import tb_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8004_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        sim_done_o,
  output logic [6:0]  sim_code_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]  state_q, state_d;
  logic [6:0]  code_q, code_d;
  logic [63:0] cyc_q, cyc_d;
  logic [31:0] hi_q, hi_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          sel;
  logic [11:0]   offset;
  logic          tx_wr;
  logic          push_req;
  logic          end_req;
  logic          push;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_bits;

  assign unused_bits = ^{data_be_i[3:1], data_wdata_i[31:8]};

  always_comb begin
    sel      = data_req_i && (data_addr_i[31:12] == BASE_ADDR[31:12]);
    offset   = data_addr_i[11:0];
    tx_wr    = data_we_i && (offset == TXDATA_OFS) && data_be_i[0];
    push_req = tx_wr && !data_wdata_i[7] && (state_q == ST_RUN);
    // A full FIFO stalls the push even if a pop frees a slot this cycle.
    data_gnt_o = sel && !(push_req && fifo_full);
    push     = data_gnt_o && push_req;
    end_req  = data_gnt_o && tx_wr && data_wdata_i[7] && (state_q == ST_RUN);
    pop      = char_valid_o && char_ready_i;
  end

  tb_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (data_wdata_i[7:0]),
    .rdata (char_o),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign char_valid_o = !fifo_empty;

  always_comb begin
    rvalid_d = data_gnt_o;
    rdata_d  = 32'h0;
    err_d    = 1'b0;
    hi_d     = hi_q;
    if (data_gnt_o) begin
      case (offset)
        TXDATA_OFS: ;
        STATUS_OFS: begin
          if (!data_we_i) begin
            rdata_d = status_word(STAT_COUNT_W'(fifo_count), fifo_full, fifo_empty,
                                  state_q == ST_DONE);
          end
        end
        CYCLE_LO_OFS: begin
          // Snapshot the upper half so a following HI read is coherent.
          if (!data_we_i) begin
            rdata_d = cyc_q[31:0];
            hi_d    = cyc_q[63:32];
          end
        end
        CYCLE_HI_OFS: begin
          if (!data_we_i) begin
            rdata_d = hi_q;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cyc_d   = cyc_q + 64'd1;
    case (state_q)
      ST_RUN: begin
        if (end_req) begin
          state_d = ST_DRAIN;
          code_d  = data_wdata_i[6:0];
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !pop) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      code_q   <= 7'h0;
      cyc_q    <= 64'h0;
      hi_q     <= 32'h0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      cyc_q    <= cyc_d;
      hi_q     <= hi_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign sim_done_o    = (state_q == ST_DONE);
  assign sim_code_o    = code_q;

endmodule

`default_nettype wire

// File: tb/tb_tb_console_dev.sv
// ---------------------------------------------------------------------------
// tb_tb_console_dev : self-checking bench for tb_console_dev.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tb_console_dev;

  localparam logic [31:0] TX_A   = 32'h8004_0200;
  localparam logic [31:0] ST_A   = 32'h8004_0204;
  localparam logic [31:0] LO_A   = 32'h8004_0208;
  localparam logic [31:0] HI_A   = 32'h8004_020C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        char_valid_o;
  logic [7:0]  char_o;
  logic        char_ready_i;
  logic        sim_done_o;
  logic [6:0]  sim_code_o;

  always #5 clk = ~clk;

  tb_console_dev dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .char_valid_o  (char_valid_o),
    .char_o        (char_o),
    .char_ready_i  (char_ready_i),
    .sim_done_o    (sim_done_o),
    .sim_code_o    (sim_code_o)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_gnt;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] resp_q[$];
  logic [7:0]  char_q[$];
  bit          ended    = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [63:0] bench_cyc;
  vec_t        vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counter reference: counts clock edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bench_cyc <= 64'h0;
    else        bench_cyc <= bench_cyc + 64'd1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = 1'b0;
    end else begin
      check("rvalid_timing", {31'h0, data_rvalid_o}, {31'h0, prev_gnt});
      if (data_rvalid_o) begin
        if (resp_q.size() == 0) begin
          check("rvalid_unexpected", 32'h1, 32'h0);
        end else begin
          logic [32:0] r;
          r = resp_q.pop_front();
          check("rdata", data_rdata_o, r[32:1]);
          check("err", {31'h0, data_err_o}, {31'h0, r[0]});
        end
      end
      if (char_valid_o && char_ready_i) begin
        if (char_q.size() == 0) begin
          check("char_unexpected", {24'h0, char_o}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] c;
          c = char_q.pop_front();
          check("char", {24'h0, char_o}, {24'h0, c});
        end
      end
      prev_gnt = data_gnt_o;
    end
  end

  task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
  endtask

  task automatic idle();
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
  endtask

  // Records the expected response and the character model for a granted access.
  task automatic expect_grant(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd, input logic er);
    resp_q.push_back({rd, er});
    if (we && addr == TX_A && be[0]) begin
      if (wdata[7]) ended = 1'b1;
      else if (!ended) char_q.push_back(wdata[7:0]);
    end
  endtask

  task automatic bus(input string name, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_gnt, input logic [31:0] exp_rdata,
                     input logic exp_err, input bit use_cyc);
    logic [31:0] rd;
    drive(we, be, addr, wdata);
    @(negedge clk);
    rd = use_cyc ? bench_cyc[31:0] : exp_rdata;
    check({name, "_gnt"}, {31'h0, data_gnt_o}, {31'h0, exp_gnt});
    if (exp_gnt) expect_grant(we, be, addr, wdata, rd, exp_err);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!char_valid_o) break;
    end
    check({name, "_drain"}, {31'h0, char_valid_o}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_gnt"},    {31'h0, data_gnt_o},    32'h0);
    check({name, "_rvalid"}, {31'h0, data_rvalid_o}, 32'h0);
    check({name, "_rdata"},  data_rdata_o,           32'h0);
    check({name, "_err"},    {31'h0, data_err_o},    32'h0);
    check({name, "_cvalid"}, {31'h0, char_valid_o},  32'h0);
    check({name, "_char"},   {24'h0, char_o},        32'h0);
    check({name, "_done"},   {31'h0, sim_done_o},    32'h0);
    check({name, "_code"},   {25'h0, sim_code_o},    32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"rd_tx",      1'b0, 4'hF, TX_A,         32'h0,      1'b1, 32'h0,      1'b0};
    vecs[1] = '{"rd_status",  1'b0, 4'hF, ST_A,         32'h0,      1'b1, 32'h200,    1'b0};
    vecs[2] = '{"rd_bad",     1'b0, 4'hF, 32'h8004_0300, 32'h0,     1'b1, 32'h0,      1'b1};
    vecs[3] = '{"wr_bad",     1'b1, 4'hF, 32'h8004_0300, 32'hDEAD,  1'b1, 32'h0,      1'b1};
    vecs[4] = '{"wr_status",  1'b1, 4'hF, ST_A,         32'hFFFF,   1'b1, 32'h0,      1'b0};
    vecs[5] = '{"wr_tx_nobe", 1'b1, 4'hE, TX_A,         32'h41,     1'b1, 32'h0,      1'b0};
    vecs[6] = '{"rd_outwin",  1'b0, 4'hF, 32'h8004_1200, 32'h0,     1'b0, 32'h0,      1'b0};
    vecs[7] = '{"wr_outwin",  1'b1, 4'hF, 32'h9004_0200, 32'h42,    1'b0, 32'h0,      1'b0};
    vecs[8] = '{"rd_status2", 1'b0, 4'hF, ST_A,         32'h0,      1'b1, 32'h200,    1'b0};
    vecs[9] = '{"rd_edge",    1'b0, 4'hF, 32'h8004_0FFC, 32'h0,     1'b1, 32'h0,      1'b1};

    rst_n = 1'b0;
    char_ready_i = 1'b1;
    idle();
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Register map and window decode.
    foreach (vecs[i]) begin
      bus(vecs[i].name, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_gnt, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
    end
    bus("rd_cyc_lo", 1'b0, 4'hF, LO_A, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    check("no_char_after_table", {31'h0, char_valid_o}, 32'h0);

    // 'H' then 'i' back to back with the sink ready.
    bus("tx_H", 1'b1, 4'h1, TX_A, 32'h48, 1'b1, 32'h0, 1'b0, 1'b0);
    bus("tx_i", 1'b1, 4'h1, TX_A, 32'h69, 1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("char_i_next", {23'h0, char_valid_o, char_o}, {23'h0, 1'b1, 8'h69});
    @(posedge clk); #1;
    char_ready_i = 1'b0;

    // Fill the FIFO and stall the ninth push.
    for (int i = 0; i < 8; i++) begin
      bus("fill", 1'b1, 4'h1, TX_A, 32'h30 + i, 1'b1, 32'h0, 1'b0, 1'b0);
    end
    bus("tx9_stall", 1'b1, 4'h1, TX_A, 32'h38, 1'b0, 32'h0, 1'b0, 1'b0);
    bus("status_full", 1'b0, 4'hF, ST_A, 32'h0, 1'b1, 32'h108, 1'b0, 1'b0);
    drive(1'b1, 4'h1, TX_A, 32'h38);
    char_ready_i = 1'b1;
    @(negedge clk);
    check("tx9_pop_cycle_gnt", {31'h0, data_gnt_o}, 32'h0);
    @(posedge clk); #1;
    char_ready_i = 1'b0;
    @(negedge clk);
    check("tx9_after_pop_gnt", {31'h0, data_gnt_o}, 32'h1);
    expect_grant(1'b1, 4'h1, TX_A, 32'h38, 32'h0, 1'b0);
    @(posedge clk); #1;
    idle();
    bus("status_full2", 1'b0, 4'hF, ST_A, 32'h0, 1'b1, 32'h108, 1'b0, 1'b0);
    char_ready_i = 1'b1;
    wait_drain("fill");

    // Cycle counter snapshot, including a carry between LO and HI reads.
    drive(1'b0, 4'hF, LO_A, 32'h0);
    force dut.cyc_q = 64'h1_0000_0010;
    #1 release dut.cyc_q;
    @(negedge clk);
    check("cyc_lo_gnt", {31'h0, data_gnt_o}, 32'h1);
    expect_grant(1'b0, 4'hF, LO_A, 32'h0, 32'h10, 1'b0);
    @(posedge clk); #1;
    bus("cyc_hi", 1'b0, 4'hF, HI_A, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0);
    drive(1'b0, 4'hF, LO_A, 32'h0);
    force dut.cyc_q = 64'h1_FFFF_FFFF;
    #1 release dut.cyc_q;
    @(negedge clk);
    check("cyc_lo2_gnt", {31'h0, data_gnt_o}, 32'h1);
    expect_grant(1'b0, 4'hF, LO_A, 32'h0, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    bus("cyc_hi_carry", 1'b0, 4'hF, HI_A, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0);

    // End of test with three characters still queued.
    char_ready_i = 1'b0;
    bus("q_a", 1'b1, 4'h1, TX_A, 32'h61, 1'b1, 32'h0, 1'b0, 1'b0);
    bus("q_b", 1'b1, 4'h1, TX_A, 32'h62, 1'b1, 32'h0, 1'b0, 1'b0);
    bus("q_c", 1'b1, 4'h1, TX_A, 32'h63, 1'b1, 32'h0, 1'b0, 1'b0);
    bus("end85", 1'b1, 4'h1, TX_A, 32'h85, 1'b1, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_held", {31'h0, sim_done_o}, 32'h0);
    end
    @(posedge clk); #1;
    char_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!char_valid_o) break;
      check("done_while_draining", {31'h0, sim_done_o}, 32'h0);
    end
    check("drain_end", {31'h0, char_valid_o}, 32'h0);
    check("done_not_early", {31'h0, sim_done_o}, 32'h0);
    @(negedge clk);
    check("done_rise", {31'h0, sim_done_o}, 32'h1);
    check("code_05", {25'h0, sim_code_o}, 32'h05);
    @(posedge clk); #1;
    bus("status_done", 1'b0, 4'hF, ST_A, 32'h0, 1'b1, 32'h0001_0200, 1'b0, 1'b0);
    bus("tx_after_done", 1'b1, 4'h1, TX_A, 32'h41, 1'b1, 32'h0, 1'b0, 1'b0);
    bus("end_again", 1'b1, 4'h1, TX_A, 32'h87, 1'b1, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("silent_after_done", {31'h0, char_valid_o}, 32'h0);
    end
    check("code_kept", {25'h0, sim_code_o}, 32'h05);
    check("done_kept", {31'h0, sim_done_o}, 32'h1);

    // Asynchronous reset while draining with a response pending.
    @(negedge clk); rst_n = 1'b0;
    #2;
    resp_q.delete(); char_q.delete(); ended = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    char_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus("rq", 1'b1, 4'h1, TX_A, 32'h70 + i, 1'b1, 32'h0, 1'b0, 1'b0);
    end
    bus("end83", 1'b1, 4'h1, TX_A, 32'h83, 1'b1, 32'h0, 1'b0, 1'b0);
    check("rvalid_pending", {31'h0, data_rvalid_o}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    resp_q.delete(); char_q.delete(); ended = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal operation after reset.
    bus("cyc_lo_after_rst", 1'b0, 4'hF, LO_A, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    bus("status_after_rst", 1'b0, 4'hF, ST_A, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0);
    char_ready_i = 1'b1;
    bus("tx_Z", 1'b1, 4'h1, TX_A, 32'h5A, 1'b1, 32'h0, 1'b0, 1'b0);
    wait_drain("tx_Z");
    bus("end_empty", 1'b1, 4'h1, TX_A, 32'h8A, 1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("done_empty_1", {31'h0, sim_done_o}, 32'h0);
    @(negedge clk);
    check("done_empty_2", {31'h0, sim_done_o}, 32'h1);
    check("code_0a", {25'h0, sim_code_o}, 32'h0A);
    repeat (2) @(negedge clk);

    check("resp_queue_empty", resp_q.size(), 32'h0);
    check("char_queue_empty", char_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tb_console_dev.md
# tb_console_dev

Memory-mapped console and simulation-control device for the CHERIoT testbench data bus. It sits downstream of the core's data port, alongside the data memory model. It accepts character writes into a small FIFO, streams them to a character sink with a valid/ready handshake, and raises a sticky end-of-test flag once all earlier characters have drained. It also exposes status and a 64-bit cycle counter for software timing.

## Interface
- BASE_ADDR, 32'h8004_0000: device window base; the window is 4 KiB (addr[31:12] match).
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of two, at least 2.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- data_req_i  in  1  bus request
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  grant, combinational
- data_rvalid_o  out  1  response valid, one cycle after grant
- data_rdata_o  out  32  read data, valid with rvalid
- data_err_o  out  1  error response, valid with rvalid
- char_valid_o  out  1  character available at FIFO head
- char_o  out  8  FIFO head character
- char_ready_i  in  1  sink accepts character
- sim_done_o  out  1  sticky end-of-test
- sim_code_o  out  7  exit code, valid when sim_done_o is 1

## Operation
- sel = data_req_i & (data_addr_i[31:12] == BASE_ADDR[31:12]); offset = data_addr_i[11:0].
- Registers:
  - 0x200 TXDATA (W). Requires be[0]. If wdata[7]=0, push wdata[7:0]. If wdata[7]=1, latch code = wdata[6:0] and request end.
  - 0x204 STATUS (R): bits [4:0] = fifo count, [8] = full, [9] = empty, [16] = sim_done.
  - 0x208 CYCLE_LO (R): reading it snapshots cycle[63:32] into the hi shadow.
  - 0x20C CYCLE_HI (R): returns the hi shadow.
- Reads of TXDATA return 0. Writes to read-only registers are ignored without error. Any other offset gives err=1 and rdata=0.
- data_gnt_o = sel & !(we & offset==0x200 & be[0] & !wdata[7] & fifo_full & state==RUN).
- TX write with be[0]=0 is granted and has no effect.
- State machine (RUN, DRAIN, DONE):
  - RUN → DRAIN on a granted end write. Code is latched in that cycle.
  - DRAIN → DONE when FIFO is empty and no pop is in flight.
  - DONE is terminal until reset.
  - In DRAIN and DONE, TX writes are granted and dropped; a second end write does not change the code.
- FIFO pop on char_valid_o & char_ready_i. char_valid_o = !empty; char_o = head entry.
- The cycle counter is 64 bits, increments every clock from reset, and wraps silently.

## Timing
- Reset values: gnt 0, rvalid 0, rdata 0, err 0, char_valid 0, char 0, sim_done 0, sim_code 0, counter 0, state RUN, FIFO empty.
- A granted push is visible on char_valid_o in the next cycle (1-cycle latency). Push and pop in the same cycle leave the count unchanged.
- When full, gnt stays low even if a pop happens in the same cycle. The push is granted in the cycle after count drops.
- rvalid pulses once per grant, exactly 1 cycle later. Back-to-back grants give back-to-back rvalids. Read data is sampled at grant.
- CYCLE_LO returns the counter value at the grant cycle.
- sim_done_o rises in the cycle after the FIFO becomes empty in DRAIN. An end write to an already-empty FIFO gives sim_done 2 cycles after grant (RUN→DRAIN, then DRAIN→DONE).
- Reset mid-operation flushes the FIFO and clears done, code, the counter and any pending rvalid immediately (asynchronous).
- Non-selected requests: gnt 0, with no side effects.

## Structure
- Package tb_console_pkg holds:
  - offset localparams: TXDATA_OFS, STATUS_OFS, CYCLE_LO_OFS, CYCLE_HI_OFS
  - state enum: RUN, DRAIN, DONE
  - STATUS bit positions
- Sub-module tb_char_fifo: a synchronous FIFO, parameter DEPTH, width 8.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Pointers are log2(DEPTH)+1 bits; wrap is detected from the MSB.

## Test plan
- Write 0x48 then 0x69 to 0x8004_0200 with char_ready=1 → char_o shows 'H' then 'i' on consecutive cycles; rvalid=1, err=0 for each write.
- char_ready=0, 9 writes with DEPTH=8 → 8 writes granted; the 9th has gnt=0 and STATUS reads 0x0000_0108. Raise ready for 1 cycle → 9th is granted the next cycle.
- With 3 characters queued and ready=0, write 0x85 → sim_done stays 0. Enable ready → done rises 1 cycle after the last pop, with sim_code=0x05. A later write of 0x41 emits nothing.
- Read 0x8004_0208 then 0x8004_020C at a counter of 0x1_0000_0010 → LO=0x10, HI=0x1. A counter carry between the two reads does not change HI.
- Read 0x8004_0300 → rvalid with err=1, rdata=0. Address 0x8004_1200 → gnt=0, no rvalid.
- Assert rst_n=0 with 4 characters queued and in DRAIN → all outputs return to reset values asynchronously. After release, normal operation resumes.
